// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: grants the single write port to the ALU or LSU,
// registers the write, and tracks in-flight destinations in a busy scoreboard for issue stalls.

module rf_wb_sb_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic q
);
    // Set beats clear so a re-issue in the commit cycle keeps the register pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= 1'b0;
        else if (set) q <= 1'b1;
        else if (clr) q <= 1'b0;
    end
endmodule

module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_wb_valid,
    input  logic [3:0]  alu_wb_addr,
    input  logic [15:0] alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        lsu_wb_valid,
    input  logic [3:0]  lsu_wb_addr,
    input  logic [15:0] lsu_wb_data,
    output logic        lsu_wb_ready,
    input  logic        iss_valid,
    input  logic [3:0]  iss_ra1,
    input  logic [3:0]  iss_ra2,
    input  logic [3:0]  iss_rd,
    input  logic        iss_rd_we,
    output logic        iss_stall,
    output logic        rf_we3,
    output logic [3:0]  rf_wa3,
    output logic [15:0] rf_wd3,
    output logic [15:0] busy
);
    localparam logic [3:0] LIM = STARVE_LIMIT[3:0];

    typedef struct packed {
        logic        vld;
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_req_t;

    wb_req_t     alu_req, lsu_req, win_req;
    logic [3:0]  starve_cnt;
    logic        lsu_pri, grant;
    logic        iss_fire;
    logic [15:1] sb_q;

    assign alu_req = '{vld: alu_wb_valid, addr: alu_wb_addr, data: alu_wb_data};
    assign lsu_req = '{vld: lsu_wb_valid, addr: lsu_wb_addr, data: lsu_wb_data};

    // ALU wins unless the LSU has waited STARVE_LIMIT cycles; a lone requester always wins.
    assign lsu_pri      = (starve_cnt == LIM);
    assign alu_wb_ready = alu_req.vld && !(lsu_req.vld && lsu_pri);
    assign lsu_wb_ready = lsu_req.vld && !alu_wb_ready;
    assign grant        = alu_wb_ready || lsu_wb_ready;
    assign win_req      = lsu_wb_ready ? lsu_req : alu_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= 4'd0;
        else if (!lsu_wb_valid || lsu_wb_ready)
            starve_cnt <= 4'd0;
        else if (starve_cnt != LIM)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // Write stage: one cycle between grant and commit; r0 writes are swallowed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we3 <= 1'b0;
            rf_wa3 <= 4'd0;
            rf_wd3 <= 16'd0;
        end else begin
            rf_we3 <= grant && (win_req.addr != 4'd0);
            if (grant) begin
                rf_wa3 <= win_req.addr;
                rf_wd3 <= win_req.data;
            end
        end
    end

    assign iss_stall = iss_valid && (
                           ((iss_ra1 != 4'd0) && busy[iss_ra1]) ||
                           ((iss_ra2 != 4'd0) && busy[iss_ra2]) ||
                           (iss_rd_we && (iss_rd != 4'd0) && busy[iss_rd]));
    assign iss_fire  = iss_valid && !iss_stall && iss_rd_we && (iss_rd != 4'd0);

    for (genvar n = 1; n < 16; n++) begin : g_sb
        rf_wb_sb_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .set   (iss_fire && (iss_rd == 4'(n))),
            .clr   (rf_we3 && (rf_wa3 == 4'(n))),
            .q     (sb_q[n])
        );
    end

    assign busy = {sb_q, 1'b0};
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grant/commit timing, starvation, hazards, r0, async reset.

module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_wb_valid, lsu_wb_valid, iss_valid, iss_rd_we;
    logic [3:0]  alu_wb_addr, lsu_wb_addr, iss_ra1, iss_ra2, iss_rd;
    logic [15:0] alu_wb_data, lsu_wb_data;
    logic        alu_wb_ready, lsu_wb_ready, iss_stall, rf_we3;
    logic [3:0]  rf_wa3;
    logic [15:0] rf_wd3, busy;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_ready(lsu_wb_ready),
        .iss_valid(iss_valid), .iss_ra1(iss_ra1), .iss_ra2(iss_ra2), .iss_rd(iss_rd),
        .iss_rd_we(iss_rd_we), .iss_stall(iss_stall),
        .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [3:0] a, input logic [15:0] d);
        alu_wb_valid = v; alu_wb_addr = a; alu_wb_data = d;
    endtask

    task automatic lsu(input logic v, input logic [3:0] a, input logic [15:0] d);
        lsu_wb_valid = v; lsu_wb_addr = a; lsu_wb_data = d;
    endtask

    task automatic iss(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] rd, input logic we);
        iss_valid = v; iss_ra1 = r1; iss_ra2 = r2; iss_rd = rd; iss_rd_we = we;
    endtask

    initial begin
        logic [3:0] alu_a;
        logic       exp_alu;

        rst_n = 1'b0;
        alu(0, 0, 0); lsu(0, 0, 0); iss(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_busy", busy, 16'h0);
        chk("rst_we3",  rf_we3, 1'b0);
        chk("rst_wa3",  rf_wa3, 4'h0);
        chk("rst_wd3",  rf_wd3, 16'h0);
        #2 rst_n = 1'b1;
        tick();

        // Single ALU write: grant now, commit visible next cycle, gone after.
        alu(1, 5, 16'hBEEF);
        #1;
        chk("s_alu_rdy", alu_wb_ready, 1'b1);
        chk("s_lsu_rdy", lsu_wb_ready, 1'b0);
        tick(); alu(0, 0, 0);
        chk("s_we3", rf_we3, 1'b1);
        chk("s_wa3", rf_wa3, 4'd5);
        chk("s_wd3", rf_wd3, 16'hBEEF);
        tick();
        chk("s_we3_off", rf_we3, 1'b0);

        // Contention: ALU wins cycles 0-2, LSU wins cycle 3, ALU again cycle 4.
        alu_a = 4'd1;
        lsu(1, 9, 16'h9999);
        for (int c = 0; c < 5; c++) begin
            alu(1, alu_a, {12'h0A0, alu_a});
            #1;
            exp_alu = (c != 3);
            chk($sformatf("c%0d_alu_rdy", c), alu_wb_ready, exp_alu);
            chk($sformatf("c%0d_lsu_rdy", c), lsu_wb_ready, !exp_alu);
            tick();
            if (exp_alu) begin
                chk($sformatf("c%0d_wa3", c), rf_wa3, alu_a);
                chk($sformatf("c%0d_wd3", c), rf_wd3, {12'h0A0, alu_a});
                alu_a = alu_a + 4'd1;
            end else begin
                chk("c3_wa3", rf_wa3, 4'd9);
                chk("c3_wd3", rf_wd3, 16'h9999);
                chk("c3_starve_clr", dut.starve_cnt, 4'd0);
                lsu(0, 0, 0);
            end
        end
        alu(0, 0, 0);
        tick();

        // Hazard: r7 goes busy, reader stalls until the LSU commit has retired.
        iss(1, 0, 0, 7, 1);
        #1 chk("h_fire_stall", iss_stall, 1'b0);
        tick();
        chk("h_busy7", busy, 16'h0080);
        iss(1, 7, 0, 8, 1);
        #1 chk("h_raw_stall", iss_stall, 1'b1);
        tick();
        chk("h_busy_hold", busy, 16'h0080);
        lsu(1, 7, 16'h7777);
        #1;
        chk("h_lsu_rdy", lsu_wb_ready, 1'b1);
        chk("h_stall_n", iss_stall, 1'b1);
        tick(); lsu(0, 0, 0);
        #1;
        chk("h_we3_n1", rf_we3, 1'b1);
        chk("h_wa3_n1", rf_wa3, 4'd7);
        chk("h_stall_n1", iss_stall, 1'b1);
        chk("h_busy_n1", busy, 16'h0080);
        tick();
        chk("h_busy_n2", busy, 16'h0000);
        chk("h_stall_n2", iss_stall, 1'b0);
        tick(); iss(0, 0, 0, 0, 0);
        chk("h_busy8", busy, 16'h0100);

        // Set/clear collision on r3: the fresh issue keeps it busy.
        alu(1, 3, 16'h3333);
        tick(); alu(0, 0, 0);
        iss(1, 0, 0, 3, 1);
        #1;
        chk("x_we3", rf_we3, 1'b1);
        chk("x_stall", iss_stall, 1'b0);
        tick(); iss(0, 0, 0, 0, 0);
        chk("x_busy", busy, 16'h0108);

        // r0: write accepted but never commits; r0 reads/writes never stall.
        alu(1, 0, 16'h1234);
        #1 chk("z_alu_rdy", alu_wb_ready, 1'b1);
        tick(); alu(0, 0, 0);
        chk("z_we3", rf_we3, 1'b0);
        iss(1, 0, 0, 0, 1);
        #1 chk("z_stall", iss_stall, 1'b0);
        tick(); iss(0, 0, 0, 0, 0);
        chk("z_busy", busy, 16'h0108);

        // Reset mid-operation: build busy=0x0090 with a write pending and starve_cnt=1.
        #2 rst_n = 1'b0;
        #1 chk("r0_busy", busy, 16'h0);
        #2 rst_n = 1'b1;
        tick();
        iss(1, 0, 0, 4, 1);
        tick();
        iss(1, 0, 0, 7, 1);
        alu(1, 4, 16'h4444);
        lsu(1, 5, 16'h5555);
        tick();
        iss(0, 0, 0, 0, 0); alu(0, 0, 0); lsu(0, 0, 0);
        chk("r_busy_pre", busy, 16'h0090);
        chk("r_we3_pre", rf_we3, 1'b1);
        chk("r_starve_pre", dut.starve_cnt, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_we3", rf_we3, 1'b0);
        chk("r_busy", busy, 16'h0);
        chk("r_starve", dut.starve_cnt, 4'd0);
        #3 rst_n = 1'b1;
        tick();
        alu(1, 2, 16'h2222);
        #1 chk("r_alu_rdy", alu_wb_ready, 1'b1);
        tick(); alu(0, 0, 0);
        chk("r_we3_post", rf_we3, 1'b1);
        chk("r_wa3_post", rf_wa3, 4'd2);
        chk("r_wd3_post", rf_wd3, 16'h2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 16x16 register file.
- Arbitrates it between two writeback requesters: the ALU writeback stage and the LSU load-return path.
- Keeps a 16-bit busy scoreboard of destinations with writes in flight, and stalls issue on RAW/WAW hazards against them.
- Sits between the issue stage, the two writeback sources and the register file.

Parameters:
- STARVE_LIMIT, 3, number of consecutive cycles the LSU may wait with valid high before it takes priority over the ALU (1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_wb_valid  input  1  ALU write request
- alu_wb_addr  input  4  ALU destination register
- alu_wb_data  input  16  ALU write data
- alu_wb_ready  output  1  ALU request granted this cycle
- lsu_wb_valid  input  1  LSU write request
- lsu_wb_addr  input  4  LSU destination register
- lsu_wb_data  input  16  LSU write data
- lsu_wb_ready  output  1  LSU request granted this cycle
- iss_valid  input  1  instruction presented at issue
- iss_ra1, iss_ra2  input  4 each  source registers of issuing instruction
- iss_rd  input  4  destination register of issuing instruction
- iss_rd_we  input  1  issuing instruction writes iss_rd
- iss_stall  output  1  hazard: issue must hold this cycle
- rf_we3  output  1  register file write enable (registered)
- rf_wa3  output  4  register file write address (registered)
- rf_wd3  output  16  register file write data (registered)
- busy  output  16  scoreboard; bit n = write to rn pending; bit 0 always 0

Behaviour:
- Handshake: a transfer occurs when valid && ready. Requesters hold valid/addr/data stable until ready. Ready is combinational from valid and priority state; alu_wb_ready and lsu_wb_ready are never both 1.
- Arbitration: the ALU has default priority. starve_cnt (4-bit) increments each cycle lsu_wb_valid=1 && lsu_wb_ready=0, saturating at STARVE_LIMIT. When starve_cnt==STARVE_LIMIT and both are valid, the LSU is granted. starve_cnt clears on any LSU grant or when lsu_wb_valid=0. A sole requester is always granted the same cycle.
- Write stage: a grant in cycle N registers addr/data. rf_we3=1 during cycle N+1 and the register file commits at the end of N+1. Grant latency is 0 cycles; commit latency is 1 cycle. Back-to-back grants every cycle are supported.
- r0: a granted write with addr 0 is accepted (ready=1) but produces rf_we3=0. busy[0] is hardwired 0.
- Scoreboard set: an issue fire (iss_valid && !iss_stall && iss_rd_we && iss_rd!=0) sets busy[iss_rd] at the clock edge.
- Scoreboard clear: rf_we3 && rf_wa3==n clears busy[n] at the same edge as the commit.
- Simultaneous set and clear of the same register: set wins.
- A write to a register whose busy bit is 0 commits normally, with no scoreboard change.
- Stall (combinational): iss_stall = iss_valid && ((ra1!=0 && busy[ra1]) || (ra2!=0 && busy[ra2]) || (iss_rd_we && iss_rd!=0 && busy[iss_rd])).
- No forwarding: a register whose commit happens at the end of cycle N+1 still stalls during N+1 and is readable at N+2.
- Reset values (async assert, sync-safe deassert): busy=0, rf_we3=0, rf_wa3=0, rf_wd3=0, starve_cnt=0. An in-flight registered write is dropped on reset. Ready outputs follow valid inputs combinationally even during reset deassertion; requesters must not drive valid while rst_n=0.

Test Plan:
- Single ALU write: alu_wb_valid=1, addr=5, data=0xBEEF at cycle 0 -> alu_wb_ready=1 in cycle 0; rf_we3=1, rf_wa3=5, rf_wd3=0xBEEF in cycle 1; rf_we3=0 in cycle 2.
- Contention/starvation with STARVE_LIMIT=3: both valid continuously (ALU addr 1..n, LSU addr 9) -> ALU granted cycles 0-2; LSU granted cycle 3; starve_cnt back to 0; ALU granted cycle 4.
- Hazard: issue fires with rd=7, iss_rd_we=1 -> busy[7]=1. Next instruction with ra1=7 -> iss_stall=1. LSU writes r7 granted cycle N -> busy[7] clears at end of N+1; stall drops in N+2.
- Set/clear collision: r3 commit in progress (rf_we3=1, rf_wa3=3) while issue fires with rd=3 in the same cycle -> busy[3]=1 after the edge.
- r0 handling: ALU write addr 0, data 0x1234 -> alu_wb_ready=1, rf_we3 stays 0. Issue with ra1=0, ra2=0, rd=0, iss_rd_we=1 -> iss_stall=0, busy unchanged.
- Reset mid-operation: busy=0x0090 with rf_we3=1 pending; assert rst_n=0 mid-cycle -> rf_we3, busy and starve_cnt go to 0 immediately, asynchronously; after release, the first ALU request is granted normally.
